gray_step_sched: RTL and testbench

Round-robin scheduler that shares one 3-bit Gray-code step counter among NREQ requesters. Each requester asks for a burst of Len counter steps, optionally preceded by a counter clear. The block grants one requester at a time, drives the counter's enable and clear, and returns the resulting Gray value and overflow status with a one-cycle Done pulse. It sits between the requesting control units and the counter instance, which has inputs Clk, Reset (sync, active-high), En and outputs Output[2:0], Overflow.

---
 rtl/gray_step_sched.sv | 123 ++++++++++++
 tb/tb_gray_step_sched.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/gray_step_sched.sv
// gray_step_sched: round-robin scheduler sharing one 3-bit Gray step counter among NREQ requesters
// Ports:
//   Clk, Reset_n          clock, asynchronous active-low reset
//   Req/Len/Clr           per-requester request level, burst length field, clear-before-step flag
//   Grant/Done/Abort      registered one-hot owner, one-cycle end-of-burst pulse, early-end flag
//   Busy                  registered, high whenever the FSM is not idle
//   Cnt_En/Cnt_Clr        drive the shared counter's En and Reset
//   Cnt_Gray/Cnt_Ovf      counter outputs, captured into Res_Gray/Res_Ovf in the DONE cycle
module gray_step_sched #(
    parameter int NREQ = 4,
    parameter int LENW = 4
) (
    input  logic                 Clk,
    input  logic                 Reset_n,
    input  logic [NREQ-1:0]      Req,
    input  logic [NREQ*LENW-1:0] Len,
    input  logic [NREQ-1:0]      Clr,
    output logic [NREQ-1:0]      Grant,
    output logic [NREQ-1:0]      Done,
    output logic                 Abort,
    output logic                 Busy,
    output logic                 Cnt_En,
    output logic                 Cnt_Clr,
    input  logic [2:0]           Cnt_Gray,
    input  logic                 Cnt_Ovf,
    output logic [2:0]           Res_Gray,
    output logic                 Res_Ovf
);
    localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;
    typedef enum logic [1:0] {IDLE, CLR, RUN, DONE} state_t;
    state_t          state_q, state_d;
    logic [IW-1:0]   ptr_q, ptr_d, own_q, own_d, win;
    logic [LENW-1:0] steps_q, steps_d;
    logic [NREQ-1:0] grant_q, grant_d;
    logic            abort_q, abort_d, busy_q, busy_d, res_ovf_q, res_ovf_d, found, own_req;
    logic [2:0]      res_gray_q, res_gray_d;
    logic [LENW-1:0] len_a [NREQ];
    for (genvar i = 0; i < NREQ; i++) begin : g_len
        assign len_a[i] = Len[i*LENW +: LENW];
    end
    // First requester at or above ptr, wrapping around.
    always_comb begin
        int idx;
        win   = ptr_q;
        found = 1'b0;
        for (int k = 0; k < NREQ; k++) begin
            idx = (int'(ptr_q) + k) % NREQ;
            if (!found && Req[IW'(idx)]) begin
                found = 1'b1;
                win   = IW'(idx);
            end
        end
    end
    assign own_req = Req[own_q];
    always_comb begin
        state_d    = state_q;
        ptr_d      = ptr_q;
        own_d      = own_q;
        steps_d    = steps_q;
        grant_d    = grant_q;
        abort_d    = abort_q;
        res_gray_d = res_gray_q;
        res_ovf_d  = res_ovf_q;
        case (state_q)
            IDLE: if (found) begin
                grant_d = NREQ'(1) << win;
                own_d   = win;
                ptr_d   = (int'(win) == NREQ - 1) ? '0 : win + 1'b1;
                steps_d = len_a[win];
                abort_d = 1'b0;
                state_d = Clr[win] ? CLR : (len_a[win] == '0) ? DONE : RUN;
            end
            CLR: state_d = (steps_q == '0) ? DONE : RUN;
            RUN: if (!own_req) begin
                state_d = DONE;
                abort_d = 1'b1;
            end else begin
                steps_d = steps_q - 1'b1;
                state_d = (steps_q == LENW'(1)) ? DONE : RUN;
            end
            DONE: begin
                state_d    = IDLE;
                grant_d    = '0;
                res_gray_d = Cnt_Gray;
                res_ovf_d  = Cnt_Ovf;
            end
            default: state_d = IDLE;
        endcase
    end
    assign busy_d = (state_d != IDLE);
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state_q    <= IDLE;
            ptr_q      <= '0;
            own_q      <= '0;
            steps_q    <= '0;
            grant_q    <= '0;
            abort_q    <= 1'b0;
            busy_q     <= 1'b0;
            res_gray_q <= '0;
            res_ovf_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            ptr_q      <= ptr_d;
            own_q      <= own_d;
            steps_q    <= steps_d;
            grant_q    <= grant_d;
            abort_q    <= abort_d;
            busy_q     <= busy_d;
            res_gray_q <= res_gray_d;
            res_ovf_q  <= res_ovf_d;
        end
    end
    assign Grant    = grant_q;
    assign Done     = (state_q == DONE) ? grant_q : '0;
    assign Abort    = (state_q == DONE) && abort_q;
    assign Busy     = busy_q;
    // A dropped owner request kills the step in the same cycle.
    assign Cnt_En   = (state_q == RUN) && own_req;
    assign Cnt_Clr  = (state_q == CLR);
    assign Res_Gray = res_gray_q;
    assign Res_Ovf  = res_ovf_q;
endmodule

// File: tb/tb_gray_step_sched.sv
// tb_gray_step_sched: table-driven and scoreboard bench for gray_step_sched with a Gray counter model
module tb_gray_step_sched;
    localparam int NREQ = 4;
    localparam int LENW = 4;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic [NREQ-1:0] req = '0;
    logic [NREQ-1:0] clr = '0;
    logic [NREQ*LENW-1:0] len = '0;
    logic [NREQ-1:0] grant, done;
    logic abort, busy, cnt_en, cnt_clr, res_ovf;
    logic [2:0] res_gray, cnt_gray;
    logic [2:0] cb = '0;
    logic cnt_ovf = 1'b0;
    int n_chk = 0;
    int n_err = 0;
    typedef struct {logic [NREQ-1:0] done; logic abort; logic [2:0] gray; logic ovf;} exp_t;
    typedef struct {int w; logic [LENW-1:0] len; logic clr; logic [2:0] gray; logic ovf; int en_n; int clr_n; int busy_n;} vec_t;
    exp_t sb[$];
    vec_t tbl[7];
    logic [2:0] rr_gray[4];

    gray_step_sched #(.NREQ(NREQ), .LENW(LENW)) dut (
        .Clk(clk), .Reset_n(rst_n), .Req(req), .Len(len), .Clr(clr),
        .Grant(grant), .Done(done), .Abort(abort), .Busy(busy),
        .Cnt_En(cnt_en), .Cnt_Clr(cnt_clr), .Cnt_Gray(cnt_gray), .Cnt_Ovf(cnt_ovf),
        .Res_Gray(res_gray), .Res_Ovf(res_ovf)
    );

    always #5 clk = ~clk;

    // External counter: sync clear, binary count shown as Gray, sticky overflow on 7->0.
    always @(posedge clk) begin
        if (cnt_clr) begin
            cb <= '0;
            cnt_ovf <= 1'b0;
        end else if (cnt_en) begin
            cb <= cb + 3'd1;
            if (cb == 3'd7) cnt_ovf <= 1'b1;
        end
    end
    assign cnt_gray = cb ^ (cb >> 1);

    function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endfunction

    // Scoreboard: pop on each Done, check results the following cycle.
    initial begin
        exp_t e;
        exp_t hold;
        bit pend;
        pend = 1'b0;
        forever begin
            @(negedge clk);
            if (!rst_n) pend = 1'b0;
            else begin
                chk("en_clr_excl", {31'b0, cnt_en & cnt_clr}, 32'd0);
                if (pend) begin
                    chk("res_gray", {29'b0, res_gray}, {29'b0, hold.gray});
                    chk("res_ovf", {31'b0, res_ovf}, {31'b0, hold.ovf});
                    pend = 1'b0;
                end
                if (done != '0) begin
                    if (sb.size() == 0) chk("unexpected_done", {28'b0, done}, 32'd0);
                    else begin
                        e = sb.pop_front();
                        chk("done", {28'b0, done}, {28'b0, e.done});
                        chk("abort", {31'b0, abort}, {31'b0, e.abort});
                        hold = e;
                        pend = 1'b1;
                    end
                end
            end
        end
    end

    task automatic run_burst(input vec_t v);
        int en_n, clr_n, busy_n, cyc;
        bit seen;
        en_n = 0; clr_n = 0; busy_n = 0; cyc = 0; seen = 1'b0;
        @(negedge clk);
        req[v.w] = 1'b1;
        len[v.w*LENW +: LENW] = v.len;
        clr[v.w] = v.clr;
        sb.push_back('{NREQ'(1) << v.w, 1'b0, v.gray, v.ovf});
        @(negedge clk);
        chk("grant", {28'b0, grant}, {28'b0, NREQ'(1) << v.w});
        while (!seen && cyc < 40) begin
            en_n += int'(cnt_en);
            clr_n += int'(cnt_clr);
            busy_n += int'(busy);
            cyc++;
            if (done != '0) begin
                seen = 1'b1;
                req[v.w] = 1'b0;
            end else @(negedge clk);
        end
        chk("burst_done_seen", {31'b0, seen}, 32'd1);
        chk("en_cycles", en_n, v.en_n);
        chk("clr_cycles", clr_n, v.clr_n);
        chk("busy_cycles", busy_n, v.busy_n);
    endtask

    task automatic wait_dones(input int n, input int limit, input string tag);
        int got, cyc;
        got = 0; cyc = 0;
        while (got < n && cyc < limit) begin
            @(negedge clk);
            cyc++;
            if (done != '0) begin
                req &= ~done;
                got++;
            end
        end
        chk(tag, got, n);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int got, cyc, n0, en_n;
        tbl[0] = '{0, 4'd5,  1'b1, 3'b111, 1'b0, 5,  1, 7};
        tbl[1] = '{1, 4'd0,  1'b1, 3'b000, 1'b0, 0,  1, 2};
        tbl[2] = '{2, 4'd15, 1'b0, 3'b100, 1'b1, 15, 0, 16};
        tbl[3] = '{3, 4'd3,  1'b0, 3'b011, 1'b1, 3,  0, 4};
        tbl[4] = '{1, 4'd2,  1'b1, 3'b011, 1'b0, 2,  1, 4};
        tbl[5] = '{0, 4'd0,  1'b0, 3'b011, 1'b0, 0,  0, 1};
        tbl[6] = '{3, 4'd0,  1'b1, 3'b000, 1'b0, 0,  1, 2};
        rr_gray[0] = 3'b001; rr_gray[1] = 3'b011; rr_gray[2] = 3'b010; rr_gray[3] = 3'b110;

        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_grant", {28'b0, grant}, 32'd0);
        chk("rst_done", {28'b0, done}, 32'd0);
        chk("rst_busy", {31'b0, busy}, 32'd0);
        chk("rst_cnt_en", {31'b0, cnt_en}, 32'd0);
        chk("rst_cnt_clr", {31'b0, cnt_clr}, 32'd0);
        chk("rst_res_gray", {29'b0, res_gray}, 32'd0);
        rst_n = 1'b1;

        for (int i = 0; i < 7; i++) run_burst(tbl[i]);

        // All four request at once: strict rotation with an idle cycle between bursts.
        @(negedge clk);
        req = '1;
        len = {NREQ{LENW'(1)}};
        clr = '0;
        for (int i = 0; i < 4; i++) sb.push_back('{NREQ'(1) << i, 1'b0, rr_gray[i], 1'b0});
        got = 0; cyc = 0;
        while (got < 4 && cyc < 40) begin
            @(negedge clk);
            cyc++;
            if (done != '0) begin
                chk("rr_slot", cyc, 3 * got + 2);
                req &= ~done;
                got++;
            end
        end
        chk("rr_count", got, 4);

        // Requester 0 keeps requesting across its Done; requester 2 must win next.
        @(negedge clk);
        req = 4'b0101;
        sb.push_back('{4'b0001, 1'b0, 3'b111, 1'b0});
        sb.push_back('{4'b0100, 1'b0, 3'b101, 1'b0});
        sb.push_back('{4'b0001, 1'b0, 3'b100, 1'b0});
        got = 0; cyc = 0; n0 = 0;
        while (got < 3 && cyc < 40) begin
            @(negedge clk);
            cyc++;
            if (done[2]) req[2] = 1'b0;
            if (done[0]) begin
                n0++;
                if (n0 == 2) req[0] = 1'b0;
            end
            if (done != '0) got++;
        end
        chk("hold_count", got, 3);

        // Abort after three steps.
        @(negedge clk);
        len[7:4] = 4'd6;
        clr[1] = 1'b1;
        req = 4'b0010;
        sb.push_back('{4'b0010, 1'b1, 3'b010, 1'b0});
        en_n = 0; cyc = 0;
        while (en_n < 3 && cyc < 20) begin
            @(negedge clk);
            cyc++;
            en_n += int'(cnt_en);
        end
        @(posedge clk);
        #1 req[1] = 1'b0;
        @(negedge clk);
        chk("abort_en_low", {31'b0, cnt_en}, 32'd0);
        chk("abort_no_done_yet", {28'b0, done}, 32'd0);
        wait_dones(1, 5, "abort_done");

        // Reset mid-RUN of requester 2 with requesters 1 and 3 pending.
        @(negedge clk);
        req = 4'b0100;
        len[11:8] = 4'd10;
        clr[2] = 1'b0;
        en_n = 0; cyc = 0;
        while (en_n < 4 && cyc < 20) begin
            @(negedge clk);
            cyc++;
            en_n += int'(cnt_en);
        end
        req[1] = 1'b1; req[3] = 1'b1;
        len[7:4] = 4'd1; clr[1] = 1'b0;
        len[15:12] = 4'd2; clr[3] = 1'b1;
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("mid_rst_grant", {28'b0, grant}, 32'd0);
        chk("mid_rst_done", {28'b0, done}, 32'd0);
        chk("mid_rst_abort", {31'b0, abort}, 32'd0);
        chk("mid_rst_busy", {31'b0, busy}, 32'd0);
        chk("mid_rst_cnt_en", {31'b0, cnt_en}, 32'd0);
        chk("mid_rst_cnt_clr", {31'b0, cnt_clr}, 32'd0);
        chk("mid_rst_res_gray", {29'b0, res_gray}, 32'd0);
        chk("mid_rst_res_ovf", {31'b0, res_ovf}, 32'd0);
        req[2] = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        sb.push_back('{4'b0010, 1'b0, 3'b000, 1'b1});
        sb.push_back('{4'b1000, 1'b0, 3'b011, 1'b0});
        @(negedge clk);
        chk("rst_ptr_grant", {28'b0, grant}, 32'd2);
        wait_dones(2, 20, "post_rst_dones");

        repeat (3) @(negedge clk);
        chk("sb_empty", sb.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end
endmodule
